// File: rtl/sram_resp_if.sv
// Initiator-side strobes and address of the shared SRAM bus.
interface sram_resp_if #(
  parameter int AW = 10
);
  logic [AW-1:0] addr;
  logic          rd_;
  logic          wr_;

  modport master (output addr, output rd_, output wr_);
  modport slave  (input addr, input rd_, input wr_);
endinterface

// File: rtl/sram_resp.sv
// SRAM responder: memory side of the shared addr/rd_/wr_/mem bus.
// Runs an optional clear sweep after reset, flags read/write strobe
// conflicts and keeps saturating read/write access counters.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_INIT  | clear sweep running, one word zeroed per cycle, bus ignored
// S_READY | normal service of reads and writes
module sram_resp #(
  parameter int AW           = 10,
  parameter int DW           = 32,
  parameter int CNTW         = 16,
  parameter bit CLEAR_ON_RST = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  sram_resp_if.slave      bus,
  inout  wire  [DW-1:0]   mem,
  output logic            busy,
  output logic            conflict_err,
  output logic [CNTW-1:0] rd_count,
  output logic [CNTW-1:0] wr_count
);

  localparam int DEPTH = 1 << AW;
  // clr_ptr carries one extra bit so the terminal compare never wraps
  localparam logic [AW:0] CLR_LAST = (AW+1)'(DEPTH - 1);

  typedef enum logic {S_INIT, S_READY} state_t;

  state_t            state_q, state_d;
  logic [AW:0]       clr_ptr_q, clr_ptr_d;
  logic [CNTW-1:0]   rd_count_q, rd_count_d;
  logic [CNTW-1:0]   wr_count_q, wr_count_d;
  logic              conflict_q, conflict_d;

  logic [DW-1:0]     array_q [DEPTH];
  logic              arr_we;
  logic [AW-1:0]     arr_waddr;
  logic [DW-1:0]     arr_wdata;

  logic              rd_req;
  logic              wr_req;
  logic              drive_en;
  logic [DW-1:0]     drive_data;

  // A plain read needs rd_ low with wr_ high; any low wr_ is a write
  assign rd_req = !bus.rd_ && bus.wr_;
  assign wr_req = !bus.wr_;

  // Next-state, counter and array-write decisions
  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    conflict_d = conflict_q;
    arr_we     = 1'b0;
    arr_waddr  = bus.addr;
    arr_wdata  = mem;
    case (state_q)
      S_INIT: begin
        arr_we    = !rst;
        arr_waddr = clr_ptr_q[AW-1:0];
        arr_wdata = '0;
        clr_ptr_d = clr_ptr_q + (AW+1)'(1);
        if (clr_ptr_q == CLR_LAST) state_d = S_READY;
      end
      S_READY: begin
        if (wr_req) begin
          // a conflicting edge still writes; only the read half is dropped
          arr_we = !rst;
          if (wr_count_q != '1) wr_count_d = wr_count_q + CNTW'(1);
          if (!bus.rd_) conflict_d = 1'b1;
        end else if (rd_req) begin
          if (rd_count_q != '1) rd_count_d = rd_count_q + CNTW'(1);
        end
      end
      default: state_d = S_READY;
    endcase
  end

  // Control registers with synchronous reset; storage is left alone by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CLEAR_ON_RST ? S_INIT : S_READY;
      clr_ptr_q  <= '0;
      rd_count_q <= '0;
      wr_count_q <= '0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
      conflict_q <= conflict_d;
    end
  end

  // Storage array: sweep clears or initiator writes
  always_ff @(posedge clk) begin
    if (arr_we) array_q[arr_waddr] <= arr_wdata;
  end

  // Zero-latency read data; the sweep answers reads with zeros
  always_comb begin
    drive_en   = 1'b0;
    drive_data = '0;
    if (rd_req) begin
      drive_en = 1'b1;
      if (state_q == S_READY) drive_data = array_q[bus.addr];
    end
  end

  assign mem          = drive_en ? drive_data : {DW{1'bz}};
  assign busy         = (state_q == S_INIT);
  assign conflict_err = conflict_q;
  assign rd_count     = rd_count_q;
  assign wr_count     = wr_count_q;

endmodule

// File: tb/tb_sram_resp.sv
// Bench for sram_resp: three instances (full-size clearing, narrow counters,
// no-clear) driven by directed and random steps against a reference model.
module tb_sram_resp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
  logic drv_en_a = 1'b0, drv_en_b = 1'b0, drv_en_c = 1'b0;
  logic [31:0] drv_a = '0, drv_b = '0, drv_c = '0;
  wire  [31:0] mem_a, mem_b, mem_c;
  assign mem_a = drv_en_a ? drv_a : 32'bz;
  assign mem_b = drv_en_b ? drv_b : 32'bz;
  assign mem_c = drv_en_c ? drv_c : 32'bz;

  logic busy_a, busy_b, busy_c, conf_a, conf_b, conf_c;
  logic [15:0] rdc_a, wrc_a, rdc_c, wrc_c;
  logic [3:0]  rdc_b, wrc_b;

  sram_resp_if #(.AW(10)) if_a ();
  sram_resp_if #(.AW(4))  if_b ();
  sram_resp_if #(.AW(4))  if_c ();

  sram_resp #(.AW(10), .DW(32), .CNTW(16), .CLEAR_ON_RST(1'b1)) dut_a (
    .clk(clk), .rst(rst_a), .bus(if_a), .mem(mem_a), .busy(busy_a),
    .conflict_err(conf_a), .rd_count(rdc_a), .wr_count(wrc_a));
  sram_resp #(.AW(4), .DW(32), .CNTW(4), .CLEAR_ON_RST(1'b1)) dut_b (
    .clk(clk), .rst(rst_b), .bus(if_b), .mem(mem_b), .busy(busy_b),
    .conflict_err(conf_b), .rd_count(rdc_b), .wr_count(wrc_b));
  sram_resp #(.AW(4), .DW(32), .CNTW(16), .CLEAR_ON_RST(1'b0)) dut_c (
    .clk(clk), .rst(rst_c), .bus(if_c), .mem(mem_c), .busy(busy_c),
    .conflict_err(conf_c), .rd_count(rdc_c), .wr_count(wrc_c));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: per instance word array, remaining sweep edges, counters
  logic [31:0] m [3][1024];
  int bl [3];
  int rdc [3];
  int wrc [3];
  bit cf [3];
  logic last_busy;

  function automatic int depth_of(input int id);
    return (id == 0) ? 1024 : 16;
  endfunction
  function automatic int cmax_of(input int id);
    return (id == 1) ? 15 : 65535;
  endfunction
  function automatic bit clr_of(input int id);
    return (id != 2);
  endfunction

  task automatic chk(input int id, input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL inst%0d %s: observed %h expected %h", id, tag, obs, exp);
    end
  endtask

  task automatic set_bus(input int id, input logic r, input logic rdn,
                         input logic wrn, input int ad, input logic [31:0] dat);
    case (id)
      0: begin rst_a = r; if_a.addr = ad[9:0]; if_a.rd_ = rdn; if_a.wr_ = wrn;
               drv_en_a = !wrn; drv_a = dat; end
      1: begin rst_b = r; if_b.addr = ad[3:0]; if_b.rd_ = rdn; if_b.wr_ = wrn;
               drv_en_b = !wrn; drv_b = dat; end
      default: begin rst_c = r; if_c.addr = ad[3:0]; if_c.rd_ = rdn; if_c.wr_ = wrn;
               drv_en_c = !wrn; drv_c = dat; end
    endcase
  endtask

  // One bus cycle on instance id: drive at negedge, check read data before the
  // edge, advance the model on the edge, check status after it
  task automatic step(input int id, input bit r, input bit rdn, input bit wrn,
                      input int ad, input logic [31:0] dat);
    logic [31:0] exp_mem, o_mem, o_rdc, o_wrc;
    logic o_busy, o_conf;
    int a;
    a = ad % depth_of(id);
    set_bus(id, r, rdn, wrn, ad, dat);
    #1;
    if (!rdn && wrn)  exp_mem = (bl[id] > 0) ? 32'h0 : m[id][a];
    else if (!wrn)    exp_mem = dat;
    else              exp_mem = 32'bz;
    o_mem = (id == 0) ? mem_a : (id == 1) ? mem_b : mem_c;
    chk(id, "mem", o_mem, exp_mem);
    @(posedge clk);
    if (r) begin
      rdc[id] = 0; wrc[id] = 0; cf[id] = 1'b0;
      bl[id] = clr_of(id) ? depth_of(id) : 0;
    end else if (bl[id] > 0) begin
      bl[id]--;
      if (bl[id] == 0)
        for (int k = 0; k < depth_of(id); k++) m[id][k] = 32'h0;
    end else if (!wrn) begin
      m[id][a] = dat;
      if (wrc[id] < cmax_of(id)) wrc[id]++;
      if (!rdn) cf[id] = 1'b1;
    end else if (!rdn) begin
      if (rdc[id] < cmax_of(id)) rdc[id]++;
    end
    @(negedge clk);
    case (id)
      0: begin o_busy = busy_a; o_conf = conf_a; o_rdc = {16'h0, rdc_a}; o_wrc = {16'h0, wrc_a}; end
      1: begin o_busy = busy_b; o_conf = conf_b; o_rdc = {28'h0, rdc_b}; o_wrc = {28'h0, wrc_b}; end
      default: begin o_busy = busy_c; o_conf = conf_c; o_rdc = {16'h0, rdc_c}; o_wrc = {16'h0, wrc_c}; end
    endcase
    last_busy = o_busy;
    chk(id, "busy", {31'h0, o_busy}, {31'h0, (bl[id] > 0)});
    chk(id, "conflict_err", {31'h0, o_conf}, {31'h0, cf[id]});
    chk(id, "rd_count", o_rdc, rdc[id]);
    chk(id, "wr_count", o_wrc, wrc[id]);
    set_bus(id, 1'b0, 1'b1, 1'b1, ad, 32'h0);
  endtask

  task automatic idle(input int id);
    step(id, 1'b0, 1'b1, 1'b1, 0, 32'h0);
  endtask
  task automatic rd(input int id, input int ad);
    step(id, 1'b0, 1'b0, 1'b1, ad, 32'h0);
  endtask
  task automatic wr(input int id, input int ad, input logic [31:0] dat);
    step(id, 1'b0, 1'b1, 1'b0, ad, dat);
  endtask

  // Random mix of reads, writes, conflicts and idles over a small address window
  task automatic traffic(input int id, input int n, input int amax);
    int op;
    int ad;
    for (int i = 0; i < n; i++) begin
      op = $urandom_range(0, 9);
      ad = $urandom_range(0, amax);
      if (op < 4)       rd(id, ad);
      else if (op < 8)  wr(id, ad, $urandom);
      else if (op == 8) step(id, 1'b0, 1'b0, 1'b0, ad, $urandom);
      else              idle(id);
    end
  endtask

  initial begin
    int cnt;
    int guard;
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 1024; k++) m[i][k] = 32'h0;
      bl[i] = 0; rdc[i] = 0; wrc[i] = 0; cf[i] = 1'b0;
    end
    if_a.addr = '0; if_a.rd_ = 1'b1; if_a.wr_ = 1'b1;
    if_b.addr = '0; if_b.rd_ = 1'b1; if_b.wr_ = 1'b1;
    if_c.addr = '0; if_c.rd_ = 1'b1; if_c.wr_ = 1'b1;
    @(negedge clk);

    // Reset and full sweep on A; accesses during the sweep are ignored
    step(0, 1'b1, 1'b1, 1'b1, 0, 32'h0);
    cnt = last_busy ? 1 : 0;
    wr(0, 10'h001, 32'h0000_1234);
    if (last_busy) cnt++;
    rd(0, 10'h001);
    if (last_busy) cnt++;
    step(0, 1'b0, 1'b0, 1'b0, 10'h002, 32'h5555_0000);
    if (last_busy) cnt++;
    guard = 0;
    while (last_busy && guard < 1100) begin
      idle(0);
      if (last_busy) cnt++;
      guard++;
    end
    chk(0, "sweep_busy_cycles", cnt, 1024);

    // Write then read-back next cycle
    wr(0, 10'h005, 32'hDEAD_BEEF);
    rd(0, 10'h005);
    chk(0, "t2_wr_count", {16'h0, wrc_a}, 32'd1);
    chk(0, "t2_rd_count", {16'h0, rdc_a}, 32'd1);
    rd(0, 10'h3FF);
    rd(0, 10'h001);
    rd(0, 10'h002);

    // Conflict: write happens, read not counted, flag sticks
    cnt = rdc_a;
    step(0, 1'b0, 1'b0, 1'b0, 10'h010, 32'hA5A5_A5A5);
    chk(0, "t4_rd_count_held", {16'h0, rdc_a}, cnt);
    idle(0);
    rd(0, 10'h010);
    chk(0, "t4_conflict_sticky", {31'h0, conf_a}, 32'd1);

    traffic(0, 400, 31);
    for (int i = 0; i < 8; i++) rd(0, $urandom_range(0, 1023));

    // Reset mid-sweep restarts the full sweep
    step(0, 1'b1, 1'b1, 1'b1, 0, 32'h0);
    for (int i = 0; i < 499; i++) idle(0);
    step(0, 1'b1, 1'b1, 1'b1, 0, 32'h0);
    cnt = last_busy ? 1 : 0;
    guard = 0;
    while (last_busy && guard < 1100) begin
      idle(0);
      if (last_busy) cnt++;
      guard++;
    end
    chk(0, "restart_busy_cycles", cnt, 1024);
    rd(0, 10'h005);
    rd(0, 10'h010);

    // Narrow counters saturate
    step(1, 1'b1, 1'b1, 1'b1, 0, 32'h0);
    for (int i = 0; i < 16; i++) idle(1);
    for (int i = 0; i < 20; i++) rd(1, $urandom_range(0, 255));
    chk(1, "t5_rd_count_sat", {28'h0, rdc_b}, 32'hF);
    for (int i = 0; i < 18; i++) wr(1, $urandom_range(0, 255), $urandom);
    chk(1, "t5_wr_count_sat", {28'h0, wrc_b}, 32'hF);
    traffic(1, 60, 255);

    // No-clear instance: contents survive reset
    step(2, 1'b1, 1'b1, 1'b1, 0, 32'h0);
    for (int i = 0; i < 16; i++) wr(2, i, $urandom);
    step(2, 1'b1, 1'b1, 1'b1, 0, 32'h0);
    for (int i = 0; i < 16; i++) rd(2, i);
    traffic(2, 100, 15);
    step(2, 1'b1, 1'b1, 1'b1, 0, 32'h0);
    for (int i = 0; i < 16; i++) rd(2, i);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
